// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction prefetch queue (fetch_queue, fetch_fifo).
package fetch_pkg;

  localparam int FQ_DEPTH_DEFAULT = 4;
  localparam int FQ_AW            = 32;
  localparam int FQ_DW            = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [FQ_DW-1:0] instr;
    logic [FQ_AW-1:0] pcplus1;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {instr, pcplus1} entries with a registered head.
// The head register keeps the last presented entry once the queue drains.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        pushData,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr, rdPtr, rdPtrNext;
  logic [WIDTH-1:0] headQ, headNext;
  logic             doPush, doPop;

  always_comb begin
    empty     = (count == '0);
    full      = (count == CNT_FULL);
    doPop     = pop && !empty;
    doPush    = push && (!full || doPop);
    rdPtrNext = rdPtr + PW'(1);
    // Next head: the incoming entry if it lands at the head, else the second entry on a pop.
    headNext  = headQ;
    if (doPush && (empty || (doPop && count == CNT_ONE)))
      headNext = pushData;
    else if (doPop && count != CNT_ONE)
      headNext = mem[rdPtrNext];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      headQ <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      if (doPop)  rdPtr <= rdPtrNext;
      count <= count + (PW+1)'(doPush) - (PW+1)'(doPop);
      headQ <= headNext;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr] <= pushData;
  end

  assign head = headQ;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch stage: PC register, single-outstanding imem request FSM, redirect flush.
// Optional FETCHQ_BYPASS_EN forwards an ack straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEFAULT,
  parameter int AW    = FQ_AW,
  parameter int DW    = FQ_DW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  input  logic          stallD,
  input  logic          pcsrcD,
  input  logic [AW-1:0] pcbranchD,
  output logic          validD,
  output logic [DW-1:0] instrD,
  output logic [AW-1:0] pcplus1D,
  output logic          emptyF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  fetch_state_t    state, stateNext;
  logic [AW-1:0]   pc, pcNext, addrQ, addrNext, addrPlus1;
  logic [CW-1:0]   count, countAfter;
  logic [DW+AW-1:0] headEntry;
  logic            fifoEmpty, fifoFull, ackKeep, bypass, push, pop;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW + AW)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (pcsrcD),
    .push     (push),
    .pop      (pop),
    .pushData ({imem_data, addrPlus1}),
    .head     (headEntry),
    .count    (count),
    .empty    (fifoEmpty),
    .full     (fifoFull)
  );

  assign imem_req  = (state != IDLE);
  assign imem_addr = addrQ;
  assign emptyF    = fifoEmpty;

  always_comb begin
    addrPlus1 = addrQ + AW'(1);
    ackKeep   = (state == WAIT) && imem_ack && !pcsrcD;
`ifdef FETCHQ_BYPASS_EN
    bypass    = ackKeep && fifoEmpty;
`else
    bypass    = 1'b0;
`endif
    validD              = !fifoEmpty || bypass;
    {instrD, pcplus1D}  = headEntry;
    if (bypass) begin
      instrD   = imem_data;
      pcplus1D = addrPlus1;
    end
    // Redirect wins: neither the head nor the returning word is consumed that cycle.
    pop        = !fifoEmpty && !stallD && !pcsrcD;
    push       = ackKeep && !(bypass && !stallD);
    countAfter = count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      addrQ <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      addrQ <= addrNext;
    end
  end

  always_comb begin
    stateNext = state;
    pcNext    = pc;
    addrNext  = addrQ;
    case (state)
      IDLE: begin
        if (pcsrcD) begin
          pcNext = pcbranchD;
        end else if (!fifoFull) begin
          stateNext = WAIT;
          addrNext  = pc;
        end
      end
      WAIT: begin
        if (pcsrcD) begin
          pcNext    = pcbranchD;
          stateNext = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          pcNext = addrPlus1;
          // Back-to-back reissue keeps one fetch per cycle with a zero-wait memory.
          if (countAfter < CNT_DEPTH) addrNext  = addrPlus1;
          else                        stateNext = IDLE;
        end
      end
      DISCARD: begin
        if (pcsrcD)   pcNext    = pcbranchD;
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
